// File: rtl/g76_mini_pkg.sv
// Shared constants for the MCU pixel read-back path: the register map, STATUS
// bit positions, default screen geometry and the fetch FSM state type.
package g76_mini_pkg;

  localparam logic [2:0] REG_RX_LOW  = 3'd4;
  localparam logic [2:0] REG_RX_HIGH = 3'd5;
  localparam logic [2:0] REG_RY      = 3'd6;
  localparam logic [2:0] REG_RDATA   = 3'd7;
  localparam logic [2:0] REG_STATUS  = 3'd4;

  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_VALID_BIT = 1;

  localparam int H_RES_DEFAULT = 320;
  localparam int V_RES_DEFAULT = 240;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetchState_t;

endpackage

// File: rtl/bus_strobe_sync.sv
// Brings one asynchronous MCU strobe into the clock domain through a three-stage
// shift register and reports one-cycle rise and fall events from its last two taps.
module bus_strobe_sync (
  input  logic clock,
  input  logic reset,
  input  logic strobe,
  output logic rise,
  output logic fall
);

  logic [2:0] syncReg;

  // Shift the raw strobe through the synchronizer chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      syncReg <= 3'b000;
    end else begin
      syncReg <= {syncReg[1:0], strobe};
    end
  end

  assign rise = syncReg[1] & ~syncReg[2];
  assign fall = ~syncReg[1] & syncReg[2];

endmodule

// File: rtl/mcu_read_port.sv
// MCU-side pixel read-back port. The MCU loads a coordinate over the 8-bit bus,
// the block fetches that pixel from the memory manager and holds it for RDATA.
// Optional feature macro: MCU_READ_AUTOINC_EN (an RDATA read advances the
// coordinate with screen wrap and starts the next fetch).
import g76_mini_pkg::*;

module mcu_read_port #(
  parameter int H_RES = H_RES_DEFAULT,
  parameter int V_RES = V_RES_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mcu_chip_select,
  input  logic       mcu_write_enable,
  input  logic       mcu_read_enable,
  input  logic [2:0] mcu_register_select,
  input  logic [7:0] mcu_data_in,
  output logic [7:0] mcu_data_out,
  output logic       mcu_data_oe,
  output logic [8:0] mem_x_coord,
  output logic [7:0] mem_y_coord,
  output logic       mem_read_request,
  input  logic [7:0] mem_read_data,
  input  logic       mem_read_complete
);

  localparam logic [8:0] RX_LAST = 9'(H_RES - 1);
  localparam logic [7:0] RY_LAST = 8'(V_RES - 1);

  fetchState_t state;
  fetchState_t stateNext;

  logic       writeEvent;
  logic       unusedWriteFall;
  logic       readRise;
  logic       readFall;
  logic       rxLowWr;
  logic       rxHighWr;
  logic       ryWr;
  logic       coordWr;
  logic       autoReload;
  logic       pendingNow;
  logic       launch;
  logic       accept;
  logic [8:0] rx;
  logic [7:0] ry;
  logic [8:0] rxNext;
  logic [7:0] ryNext;
  logic       pending;
  logic       valid;
  logic [7:0] pixelReg;
  logic [7:0] statusWord;

  bus_strobe_sync writeSync (
    .clock (clock),
    .reset (reset),
    .strobe(mcu_chip_select & ~mcu_write_enable),
    .rise  (writeEvent),
    .fall  (unusedWriteFall)
  );

  bus_strobe_sync readSync (
    .clock (clock),
    .reset (reset),
    .strobe(mcu_chip_select & mcu_read_enable),
    .rise  (readRise),
    .fall  (readFall)
  );

  assign rxLowWr  = writeEvent && (mcu_register_select == REG_RX_LOW);
  assign rxHighWr = writeEvent && (mcu_register_select == REG_RX_HIGH);
  assign ryWr     = writeEvent && (mcu_register_select == REG_RY);
  assign coordWr  = rxLowWr | rxHighWr | ryWr;

`ifdef MCU_READ_AUTOINC_EN
  logic readIsData;

  // Remember whether the read strobe now in progress addresses RDATA, since the
  // register select may already have moved on by the time its fall is seen.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      readIsData <= 1'b0;
    end else if (readRise) begin
      readIsData <= (mcu_register_select == REG_RDATA);
    end
  end

  assign autoReload = readFall & readIsData;
`else
  logic unusedReadEvents;
  assign unusedReadEvents = readRise | readFall;
  assign autoReload       = 1'b0;
`endif

  // Work out the coordinate after this cycle's bus write or auto-increment step.
  always_comb begin
    rxNext = rx;
    ryNext = ry;
    if (rxLowWr) begin
      rxNext[7:0] = mcu_data_in;
    end
    if (rxHighWr) begin
      rxNext[8] = mcu_data_in[0];
    end
    if (ryWr) begin
      ryNext = mcu_data_in;
    end
    if (autoReload) begin
      if (rx == RX_LAST) begin
        rxNext = 9'd0;
        ryNext = (ry == RY_LAST) ? 8'd0 : ry + 8'd1;
      end else begin
        rxNext = rx + 9'd1;
      end
    end
  end

  // Hold the fetch FSM state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Decide whether to launch, keep or discard a fetch; a retarget that arrives
  // with the completion pulse counts as pending so that stale data never lands.
  always_comb begin
    stateNext  = state;
    launch     = 1'b0;
    accept     = 1'b0;
    pendingNow = pending | coordWr | autoReload;
    case (state)
      IDLE: begin
        if (ryWr || autoReload) begin
          launch    = 1'b1;
          stateNext = FETCH;
        end
      end
      FETCH: begin
        if (mem_read_complete) begin
          if (pendingNow) begin
            launch = 1'b1;
          end else begin
            accept    = 1'b1;
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Coordinate registers, fetch request, captured pixel and VALID flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx               <= 9'd0;
      ry               <= 8'd0;
      mem_x_coord      <= 9'd0;
      mem_y_coord      <= 8'd0;
      mem_read_request <= 1'b0;
      valid            <= 1'b0;
      pixelReg         <= 8'd0;
    end else begin
      rx <= rxNext;
      ry <= ryNext;
      if (launch) begin
        mem_x_coord      <= rxNext;
        mem_y_coord      <= ryNext;
        mem_read_request <= 1'b1;
        valid            <= 1'b0;
      end else if (accept) begin
        pixelReg         <= mem_read_data;
        mem_read_request <= 1'b0;
        valid            <= 1'b1;
      end else if (rxLowWr || rxHighWr) begin
        valid <= 1'b0;
      end
    end
  end

  // Track a coordinate change that arrived while a fetch was outstanding.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (state != FETCH || mem_read_complete) begin
      pending <= 1'b0;
    end else if (coordWr || autoReload) begin
      pending <= 1'b1;
    end
  end

  // Assemble the STATUS word; BUSY is exactly the outstanding request.
  always_comb begin
    statusWord                   = 8'h00;
    statusWord[STATUS_BUSY_BIT]  = mem_read_request;
    statusWord[STATUS_VALID_BIT] = valid;
  end

  // Register the read-back value for whichever register the MCU is addressing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcu_data_out <= 8'h00;
    end else begin
      case (mcu_register_select)
        REG_RDATA:  mcu_data_out <= pixelReg;
        REG_STATUS: mcu_data_out <= statusWord;
        default:    mcu_data_out <= 8'h00;
      endcase
    end
  end

  assign mcu_data_oe = mcu_chip_select && mcu_read_enable &&
                       ((mcu_register_select == REG_STATUS) ||
                        (mcu_register_select == REG_RDATA));

endmodule

// File: tb/tb_mcu_read_port.sv
// Scoreboard bench for mcu_read_port: expected fetch coordinates, bus read
// values and direct signal checks are queued as stimulus is issued; one monitor
// process drains them as the DUT presents requests and read data.
module tb_mcu_read_port;
  import g76_mini_pkg::*;

  typedef struct {
    logic       oe;
    logic [7:0] data;
    logic [2:0] sel;
  } busExp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       mcu_chip_select;
  logic       mcu_write_enable;
  logic       mcu_read_enable;
  logic [2:0] mcu_register_select;
  logic [7:0] mcu_data_in;
  logic [7:0] mcu_data_out;
  logic       mcu_data_oe;
  logic [8:0] mem_x_coord;
  logic [7:0] mem_y_coord;
  logic       mem_read_request;
  logic [7:0] mem_read_data = 8'h00;
  logic       memComplete = 1'b0;
  logic       lateComplete;
  logic       memStall;
  logic       busSample;
  logic       finalCheck;
  logic       finalDone = 1'b0;
  logic       prevReq = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int memWait = 0;

  logic [16:0] reqQ[$];
  logic [7:0]  memData[$];
  busExp_t     busQ[$];
  chk_t        checkQ[$];

  logic [8:0] modelRx;
  logic [7:0] modelRy;
  logic [7:0] expPixel;
  logic [7:0] fillPixel;

  mcu_read_port dut (
    .clock              (clock),
    .reset              (reset),
    .mcu_chip_select    (mcu_chip_select),
    .mcu_write_enable   (mcu_write_enable),
    .mcu_read_enable    (mcu_read_enable),
    .mcu_register_select(mcu_register_select),
    .mcu_data_in        (mcu_data_in),
    .mcu_data_out       (mcu_data_out),
    .mcu_data_oe        (mcu_data_oe),
    .mem_x_coord        (mem_x_coord),
    .mem_y_coord        (mem_y_coord),
    .mem_read_request   (mem_read_request),
    .mem_read_data      (mem_read_data),
    .mem_read_complete  (memComplete | lateComplete)
  );

  always #5 clock = ~clock;

  // Memory manager model: answer each request four clocks later unless stalled.
  always @(negedge clock) begin
    memComplete = 1'b0;
    if (reset || !mem_read_request || memStall) begin
      memWait = 0;
    end else begin
      memWait++;
      if (memWait >= 4) begin
        memComplete = 1'b1;
        memWait     = 0;
        if (memData.size() > 0) mem_read_data = memData.pop_front();
        else mem_read_data = 8'hEE;
      end
    end
  end

  // Monitor: score new fetch launches, sampled bus reads and queued direct checks.
  always @(posedge clock) begin
    logic [16:0] expCoord;
    busExp_t     be;
    chk_t        c;
    #1;
    if (mem_read_request && (!prevReq || memComplete || lateComplete)) begin
      vectors++;
      if (reqQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpectedRequest actual x=%0d y=%0d required no request",
                 mem_x_coord, mem_y_coord);
      end else begin
        expCoord = reqQ.pop_front();
        if ({mem_x_coord, mem_y_coord} !== expCoord) begin
          miscompares++;
          $display("[TB] FAIL fetchCoord actual x=%0d y=%0d required x=%0d y=%0d",
                   mem_x_coord, mem_y_coord, expCoord[16:8], expCoord[7:0]);
        end
      end
    end
    prevReq = mem_read_request;
    if (busSample) begin
      vectors++;
      if (busQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL busRead actual oe=%0b data=%02h required nothing queued",
                 mcu_data_oe, mcu_data_out);
      end else begin
        be = busQ.pop_front();
        if (mcu_data_oe !== be.oe || (be.oe && mcu_data_out !== be.data)) begin
          miscompares++;
          $display("[TB] FAIL busRead sel=%0d actual oe=%0b data=%02h required oe=%0b data=%02h",
                   be.sel, mcu_data_oe, mcu_data_out, be.oe, be.data);
        end
      end
    end
    while (checkQ.size() > 0) begin
      c = checkQ.pop_front();
      vectors++;
      if (c.act !== c.exp) begin
        miscompares++;
        $display("[TB] FAIL %s actual %0h required %0h", c.name, c.act, c.exp);
      end
    end
    if (finalCheck && !finalDone) begin
      vectors += 2;
      if (reqQ.size() != 0) begin
        miscompares++;
        $display("[TB] FAIL missingRequests actual %0d outstanding required 0", reqQ.size());
      end
      if (busQ.size() != 0) begin
        miscompares++;
        $display("[TB] FAIL missingBusReads actual %0d outstanding required 0", busQ.size());
      end
      finalDone = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    checkQ.push_back(c);
  endtask

  task automatic expectFetch(input logic [8:0] x, input logic [7:0] y, input logic [7:0] pix);
    reqQ.push_back({x, y});
    memData.push_back(pix);
  endtask

  // Bus write: strobe held four clocks, then three idle clocks.
  task automatic applyStimulus(input logic [2:0] sel, input logic [7:0] data);
    @(negedge clock);
    mcu_register_select = sel;
    mcu_data_in         = data;
    mcu_chip_select     = 1'b1;
    mcu_write_enable    = 1'b0;
    repeat (4) @(negedge clock);
    mcu_chip_select  = 1'b0;
    mcu_write_enable = 1'b1;
    if (sel == REG_RX_LOW) modelRx[7:0] = data;
    if (sel == REG_RX_HIGH) modelRx[8] = data[0];
    if (sel == REG_RY) modelRy = data;
    repeat (3) @(negedge clock);
  endtask

  task automatic busRead(input logic [2:0] sel, input logic expOe, input logic [7:0] expData);
    busExp_t be;
    be.oe   = expOe;
    be.data = expData;
    be.sel  = sel;
    busQ.push_back(be);
    @(negedge clock);
    mcu_register_select = sel;
    mcu_chip_select     = 1'b1;
    mcu_read_enable     = 1'b1;
    repeat (3) @(posedge clock);
    #2 busSample = 1'b1;
    @(posedge clock);
    #2 busSample = 1'b0;
    @(negedge clock);
    mcu_chip_select = 1'b0;
    mcu_read_enable = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic waitIdle();
    int i;
    repeat (4) @(posedge clock);
    i = 0;
    while (mem_read_request && i < 400) begin
      @(posedge clock);
      i++;
    end
    #1 checkOutput("idleTimeout", mem_read_request, 0);
  endtask

  task automatic waitReqHigh();
    int i;
    i = 0;
    while (!mem_read_request && i < 100) begin
      @(posedge clock);
      i++;
    end
    #1 checkOutput("requestTimeout", mem_read_request, 1);
  endtask

  // RDATA read; with auto-increment the model advances and expects the next fetch.
  task automatic readRdata();
`ifdef MCU_READ_AUTOINC_EN
    logic [8:0] nx;
    logic [7:0] ny;
    if (modelRx == 9'd319) begin
      nx = 9'd0;
      ny = (modelRy == 8'd239) ? 8'd0 : modelRy + 8'd1;
    end else begin
      nx = modelRx + 9'd1;
      ny = modelRy;
    end
    fillPixel = fillPixel + 8'd1;
    expectFetch(nx, ny, fillPixel);
    busRead(REG_RDATA, 1'b1, expPixel);
    modelRx = nx;
    modelRy = ny;
    waitIdle();
    expPixel = fillPixel;
`else
    busRead(REG_RDATA, 1'b1, expPixel);
`endif
  endtask

  initial begin
    reset               = 1'b1;
    mcu_chip_select     = 1'b0;
    mcu_write_enable    = 1'b1;
    mcu_read_enable     = 1'b0;
    mcu_register_select = 3'd0;
    mcu_data_in         = 8'h00;
    lateComplete        = 1'b0;
    memStall            = 1'b0;
    busSample           = 1'b0;
    finalCheck          = 1'b0;
    modelRx             = 9'd0;
    modelRy             = 8'd0;
    expPixel            = 8'h00;
    fillPixel           = 8'h80;

    #1;
    checkOutput("resetRequest", mem_read_request, 0);
    checkOutput("resetX", mem_x_coord, 0);
    checkOutput("resetY", mem_y_coord, 0);
    checkOutput("resetDataOut", mcu_data_out, 0);
    checkOutput("resetOe", mcu_data_oe, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // T1: basic fetch at (0x110, 0x20), request held while memory stalls.
    applyStimulus(REG_RX_LOW, 8'h10);
    applyStimulus(REG_RX_HIGH, 8'h01);
    memStall = 1'b1;
    expectFetch(9'h110, 8'h20, 8'hA5);
    applyStimulus(REG_RY, 8'h20);
    checkOutput("t1RequestUp", mem_read_request, 1);
    checkOutput("t1X", mem_x_coord, 9'h110);
    checkOutput("t1Y", mem_y_coord, 8'h20);
    repeat (10) @(negedge clock);
    checkOutput("t1RequestHeld", mem_read_request, 1);
    memStall = 1'b0;
    waitIdle();
    expPixel = 8'hA5;
    busRead(REG_STATUS, 1'b1, 8'h02);
    readRdata();

    // T2: STATUS shows BUSY during a fetch and RDATA still holds the old pixel.
    memStall = 1'b1;
    expectFetch(modelRx, 8'h21, 8'h5A);
    applyStimulus(REG_RY, 8'h21);
    busRead(REG_STATUS, 1'b1, 8'h01);
`ifndef MCU_READ_AUTOINC_EN
    busRead(REG_RDATA, 1'b1, expPixel);
`endif
    memStall = 1'b0;
    waitIdle();
    expPixel = 8'h5A;
    readRdata();

    // T3: retarget mid-fetch; 0x11 is discarded and the refetch returns 0x22.
    memStall = 1'b1;
    expectFetch(modelRx, 8'h30, 8'h11);
    applyStimulus(REG_RY, 8'h30);
    expectFetch(modelRx, 8'h05, 8'h22);
    applyStimulus(REG_RY, 8'h05);
    memStall = 1'b0;
    waitIdle();
    expPixel = 8'h22;
    busRead(REG_STATUS, 1'b1, 8'h02);
    readRdata();

    // T4: coordinate (319, 239); an X write alone clears VALID without fetching.
    applyStimulus(REG_RX_LOW, 8'h3F);
    busRead(REG_STATUS, 1'b1, 8'h00);
    applyStimulus(REG_RX_HIGH, 8'h01);
    expectFetch(9'd319, 8'd239, 8'h33);
    applyStimulus(REG_RY, 8'hEF);
    waitIdle();
    expPixel = 8'h33;
`ifdef MCU_READ_AUTOINC_EN
    readRdata();
    checkOutput("t4WrapX", mem_x_coord, 0);
    checkOutput("t4WrapY", mem_y_coord, 0);
`else
    busRead(REG_RDATA, 1'b1, 8'h33);
    repeat (10) @(negedge clock);
    checkOutput("t4NoAutoFetch", mem_read_request, 0);
    expectFetch(9'd319, 8'd239, 8'h34);
    applyStimulus(REG_RY, 8'hEF);
    waitIdle();
    expPixel = 8'h34;
    busRead(REG_RDATA, 1'b1, 8'h34);
`endif

    // T5: asynchronous reset while a request is outstanding.
    memStall = 1'b1;
    reqQ.push_back({modelRx, 8'h07});
    applyStimulus(REG_RY, 8'h07);
    waitReqHigh();
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    checkOutput("t5RequestDrop", mem_read_request, 0);
    checkOutput("t5X", mem_x_coord, 0);
    checkOutput("t5Y", mem_y_coord, 0);
    checkOutput("t5DataOut", mcu_data_out, 0);
    repeat (2) @(negedge clock);
    reset    = 1'b0;
    modelRx  = 9'd0;
    modelRy  = 8'd0;
    expPixel = 8'h00;
    @(negedge clock);
    lateComplete = 1'b1;
    @(negedge clock);
    lateComplete = 1'b0;
    memStall     = 1'b0;
    repeat (5) @(negedge clock);
    checkOutput("t5LateIgnored", mem_read_request, 0);
    busRead(REG_STATUS, 1'b1, 8'h00);
    readRdata();

    // T6: writes to registers 0..3 and a read of register 2 have no effect.
    applyStimulus(3'd0, 8'hFF);
    applyStimulus(3'd1, 8'h01);
    applyStimulus(3'd2, 8'h12);
    applyStimulus(3'd3, 8'h34);
    busRead(3'd2, 1'b0, 8'h00);
    repeat (10) @(negedge clock);
    checkOutput("t6NoRequest", mem_read_request, 0);
    expectFetch(modelRx, 8'h40, 8'h66);
    applyStimulus(REG_RY, 8'h40);
    waitIdle();
    expPixel = 8'h66;
    readRdata();

    finalCheck = 1'b1;
    for (int i = 0; i < 20 && !finalDone; i++) @(posedge clock);
    repeat (2) @(posedge clock);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
